// File: rtl/jtcontra_pal_dma_pkg.sv
// Shared definitions for the palette copy scheduler.
// Holds the FSM state encoding and control register bit positions.
package jtcontra_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COPY  = 2'd2,
        LAST  = 2'd3
    } state_t;

    localparam int ARM_BIT   = 0;
    localparam int FORCE_BIT = 1;

endpackage

// File: rtl/jtcontra_pal_dma.sv
// Copies the shadow palette into the live palette at the start of vblank.
// Ports: clk/rst, LVBL, CPU control write (cpu_cen, cpu_rnw, dma_cs,
// cpu_dout), status dma_st, shadow read (shd_addr/shd_data), live write
// (pal_addr/pal_din/pal_we), busy and a one-cycle done pulse.
module jtcontra_pal_dma
    import jtcontra_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          cpu_cen,
    input  logic          cpu_rnw,
    input  logic          dma_cs,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    dma_st,
    output logic [AW-1:0] shd_addr,
    input  logic [7:0]    shd_data,
    output logic [AW-1:0] pal_addr,
    output logic [7:0]    pal_din,
    output logic          pal_we,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] CNT_MAX = '1;

    state_t        st, st_nx;
    logic          pend, pend_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic          LVBL_l;
    logic          we_q, done_q;
    logic [AW-1:0] addr_q;

    logic reg_wr, vb_fall, arm, force_go, any_bit;
    logic unused_dout;

    assign reg_wr   = cpu_cen & ~cpu_rnw & dma_cs;
    assign vb_fall  = LVBL_l & ~LVBL;
    assign arm      = cpu_dout[ARM_BIT];
    assign force_go = cpu_dout[FORCE_BIT];
    assign any_bit  = arm | force_go;
    assign unused_dout = ^cpu_dout[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            pend   <= 1'b0;
            cnt    <= '0;
            LVBL_l <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            done_q <= 1'b0;
        end else begin
            st     <= st_nx;
            pend   <= pend_nx;
            cnt    <= cnt_nx;
            LVBL_l <= LVBL;
            // the RAM answers one cycle after the address, so the
            // write side trails the read address by one clock
            we_q   <= (st == COPY);
            addr_q <= (st == COPY) ? cnt : '0;
            done_q <= (st == LAST);
        end
    end

    always_comb begin
        st_nx   = st;
        pend_nx = pend;
        cnt_nx  = cnt;
        unique case (st)
            IDLE: begin
                if (reg_wr && force_go)
                    st_nx = COPY;
                else if (reg_wr && arm)
                    st_nx = ARMED;
            end
            ARMED: begin
                // a cancel beats a simultaneous vblank edge
                if (reg_wr && force_go)
                    st_nx = COPY;
                else if (reg_wr && !any_bit)
                    st_nx = IDLE;
                else if (vb_fall)
                    st_nx = COPY;
            end
            COPY: begin
                if (reg_wr)
                    pend_nx = any_bit;
                if (cnt == CNT_MAX)
                    st_nx = LAST;
                else
                    cnt_nx = cnt + 1'b1;
            end
            LAST: begin
                if (reg_wr)
                    pend_nx = any_bit;
                st_nx   = pend_nx ? ARMED : IDLE;
                pend_nx = 1'b0;
                cnt_nx  = '0;
            end
            default: st_nx = IDLE;
        endcase
    end

    // reset blanks every output in the very cycle it is asserted so
    // that an interrupted copy cannot land one more byte
    assign pal_we   = we_q & ~rst;
    assign pal_addr = pal_we ? addr_q : '0;
    assign pal_din  = pal_we ? shd_data : 8'd0;
    assign shd_addr = rst ? '0 : cnt;
    assign busy     = ~rst & ((st == COPY) | (st == LAST));
    assign done     = done_q & ~rst;
    assign dma_st   = rst ? 8'd0 :
                      {5'd0, pend, st == ARMED, busy};

endmodule

// File: doc/jtcontra_pal_dma.md
Name: jtcontra_pal_dma

Overview:
- Palette update scheduler for the 007593-equivalent colour mixer.
- The CPU writes colours into a shadow palette RAM; this block copies the whole shadow palette into the live palette RAM.
- The copy is scheduled at the start of vertical blank, so the display never shows a half-updated palette.
- Sits between the CPU decoder, the shadow RAM read port and the live palette RAM write port.

Parameters:
- AW, 8, palette address width; copy length is 2^AW bytes.

Ports:
- clk  in  1  system clock; every port is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- LVBL  in  1  vertical blank, active low.
- cpu_cen  in  1  CPU clock enable.
- cpu_rnw  in  1  CPU read-not-write.
- dma_cs  in  1  control register select.
- cpu_dout  in  8  CPU write data. Bit0 = arm, bit1 = force (start immediately).
- dma_st  out  8  status: {5'b0, pending, armed, busy}.
- shd_addr  out  AW  shadow RAM read address; the RAM has 1-cycle read latency.
- shd_data  in  8  shadow RAM read data.
- pal_addr  out  AW  live palette write address.
- pal_din  out  8  live palette write data.
- pal_we  out  1  live palette write enable.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle pulse when the last byte has been written.

Behaviour:
- Reset: all outputs are 0. State goes to IDLE; pending and the LVBL edge register are cleared.
- Control write strobe: reg_wr = cpu_cen & ~cpu_rnw & dma_cs, sampled on the rising edge of clk.
- Start trigger: vb_fall = LVBL_l & ~LVBL, where LVBL_l is LVBL registered every clk.
- States: IDLE, ARMED, COPY, LAST.
- IDLE:
  - reg_wr with bit1=1 -> COPY.
  - Else reg_wr with bit0=1 -> ARMED.
- ARMED:
  - vb_fall -> COPY.
  - reg_wr with bit1=1 -> COPY.
  - reg_wr with bits[1:0]=00 -> IDLE (cancel).
  - Arming while LVBL is already low waits for the next frame's falling edge.
- COPY:
  - Entry cycle presents shd_addr=0. shd_addr increments every clk.
  - One cycle later, pal_addr takes the previous shd_addr, pal_din takes shd_data, and pal_we=1.
  - When shd_addr reaches 2^AW-1, go to LAST. shd_addr holds at 2^AW-1.
- LAST:
  - Writes the final byte (pal_addr = 2^AW-1, pal_we=1).
  - Next cycle: busy=0 and done=1 for one cycle.
  - Then go to ARMED if pending, else IDLE. Pending is cleared on exit.
- Latency and counts:
  - From the trigger cycle, the first pal_we comes 2 clk later.
  - There are exactly 2^AW consecutive pal_we cycles.
  - done comes 2^AW+2 clk after the trigger.
- busy is high from the cycle after the trigger through the final write.
- armed status bit is high only in ARMED.
- reg_wr during COPY or LAST:
  - bit0 or bit1 set -> pending=1. Force is not honoured mid-copy; it re-arms only.
  - bits=00 -> pending=0.
  - The copy itself is never aborted.
- LVBL rising during a copy has no effect; the copy runs to completion.
- Reset mid-copy: stops immediately and pal_we=0 the same cycle. The live palette keeps the bytes already written.
- pal_addr and pal_din are 0 whenever pal_we=0.
- Address arithmetic is unsigned AW-bit. The counter never wraps, because the state leaves COPY before overflow.
- Simultaneous vb_fall and reg_wr cancel in ARMED: the cancel wins.

Decomposition:
- Shared package jtcontra_pkg holds:
  - state encoding constants: IDLE=2'd0, ARMED=2'd1, COPY=2'd2, LAST=2'd3;
  - control bit indices: ARM_BIT=0, FORCE_BIT=1.
- No sub-module is needed. A single FSM and counter is the natural size.
- The LVBL edge detector stays inline.

Test Plan:
- Arm, then LVBL 1->0 with shadow[i]=i^8'h5A:
  - pal_we high for 256 consecutive cycles starting 2 clk after the edge;
  - pal_addr 0..255 with pal_din = addr^8'h5A;
  - done 258 clk after the edge.
- Force write (cpu_dout=8'h02) with LVBL=1: copy starts without waiting; first pal_we 2 clk after reg_wr.
- Arm, then cancel (cpu_dout=8'h00) before the edge:
  - LVBL falling edge produces no pal_we;
  - dma_st=8'h00.
- Arm write at shd_addr=100 during COPY:
  - dma_st=8'h05;
  - after done, state goes to ARMED (dma_st=8'h02);
  - the next vb_fall starts a second full copy.
- Assert rst at shd_addr=37:
  - pal_we=0 and all outputs 0 the same cycle;
  - pal entries 0..35 hold new data, the rest are unchanged;
  - a later arm plus edge performs a full copy.
- Arm while LVBL=0: no copy in that blank; the copy starts at the next 1->0 transition.
